// File: rtl/inert_intf.sv
// SPI-attached inertial sensor front end: power-up wait, four register writes,
// then a six-byte rate read burst every time the sensor signals data-ready.
module inert_intf #(
  parameter int PWR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] roll_rt,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        init_done
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_ISSUE,
    INIT_WAIT,
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    UPDATE
  } state_t;

  state_t state_q, state_d;

  logic [PWR_BITS-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [1:0]          init_idx_q, init_idx_d;
  logic [2:0]          rd_idx_q, rd_idx_d;
  logic [7:0]          byte_q [6];
  logic [7:0]          byte_d [6];

  logic        wrt_q, wrt_d;
  logic [15:0] cmd_q, cmd_d;
  logic [15:0] ptch_q, ptch_d;
  logic [15:0] roll_q, roll_d;
  logic [15:0] yaw_q, yaw_d;
  logic        vld_q, vld_d;
  logic        init_done_q, init_done_d;

  logic int_meta_q, int_sync_q;
  logic done_prev_q;
  logic done_rise;

  // Only the low byte of each SPI word carries register data.
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[15:8];

  // A done level still high from the previous transaction is not a completion.
  assign done_rise = done & ~done_prev_q;

  function automatic logic [15:0] init_word(input logic [1:0] idx);
    case (idx)
      2'd0:    return 16'h0D02;
      2'd1:    return 16'h1062;
      2'd2:    return 16'h1162;
      default: return 16'h1460;
    endcase
  endfunction

  function automatic logic [15:0] rd_word(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'hA200;
      3'd1:    return 16'hA300;
      3'd2:    return 16'hA400;
      3'd3:    return 16'hA500;
      3'd4:    return 16'hA600;
      default: return 16'hA700;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    init_idx_d  = init_idx_q;
    rd_idx_d    = rd_idx_q;
    for (int i = 0; i < 6; i++) begin
      byte_d[i] = byte_q[i];
    end
    wrt_d       = 1'b0;
    cmd_d       = cmd_q;
    ptch_d      = ptch_q;
    roll_d      = roll_q;
    yaw_d       = yaw_q;
    vld_d       = 1'b0;
    init_done_d = init_done_q;

    // wrt/cmd are set on entry to an ISSUE state so they are registered and
    // coincide with that state; ISSUE always exits to WAIT, giving a 1-cycle pulse.
    case (state_q)
      PWR_WAIT: begin
        pwr_cnt_d = pwr_cnt_q + PWR_BITS'(1);
        if (pwr_cnt_d == '1) begin
          state_d = INIT_ISSUE;
          wrt_d   = 1'b1;
          cmd_d   = init_word(init_idx_q);
        end
      end

      INIT_ISSUE: begin
        state_d = INIT_WAIT;
      end

      INIT_WAIT: begin
        if (done_rise) begin
          if (init_idx_q == 2'd3) begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            state_d    = INIT_ISSUE;
            wrt_d      = 1'b1;
            cmd_d      = init_word(init_idx_q + 2'd1);
          end
        end
      end

      IDLE: begin
        if (int_sync_q) begin
          rd_idx_d = 3'd0;
          state_d  = RD_ISSUE;
          wrt_d    = 1'b1;
          cmd_d    = rd_word(3'd0);
        end
      end

      RD_ISSUE: begin
        state_d = RD_WAIT;
      end

      RD_WAIT: begin
        if (done_rise) begin
          for (int i = 0; i < 6; i++) begin
            if (rd_idx_q == 3'(i)) begin
              byte_d[i] = rd_data[7:0];
            end
          end
          if (rd_idx_q == 3'd5) begin
            // All three rates are published together from the fresh bytes.
            state_d = UPDATE;
            vld_d   = 1'b1;
            ptch_d  = {byte_d[1], byte_d[0]};
            roll_d  = {byte_d[3], byte_d[2]};
            yaw_d   = {byte_d[5], byte_d[4]};
          end else begin
            rd_idx_d = rd_idx_q + 3'd1;
            state_d  = RD_ISSUE;
            wrt_d    = 1'b1;
            cmd_d    = rd_word(rd_idx_q + 3'd1);
          end
        end
      end

      UPDATE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = PWR_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWR_WAIT;
      pwr_cnt_q   <= '0;
      init_idx_q  <= 2'd0;
      rd_idx_q    <= 3'd0;
      for (int i = 0; i < 6; i++) begin
        byte_q[i] <= 8'h00;
      end
      wrt_q       <= 1'b0;
      cmd_q       <= 16'h0000;
      ptch_q      <= 16'h0000;
      roll_q      <= 16'h0000;
      yaw_q       <= 16'h0000;
      vld_q       <= 1'b0;
      init_done_q <= 1'b0;
      int_meta_q  <= 1'b0;
      int_sync_q  <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      init_idx_q  <= init_idx_d;
      rd_idx_q    <= rd_idx_d;
      for (int i = 0; i < 6; i++) begin
        byte_q[i] <= byte_d[i];
      end
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      ptch_q      <= ptch_d;
      roll_q      <= roll_d;
      yaw_q       <= yaw_d;
      vld_q       <= vld_d;
      init_done_q <= init_done_d;
      int_meta_q  <= INT;
      int_sync_q  <= int_meta_q;
      done_prev_q <= done;
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign ptch_rt   = ptch_q;
  assign roll_rt   = roll_q;
  assign yaw_rt    = yaw_q;
  assign vld       = vld_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_inert_intf.sv
// Scoreboard bench for inert_intf: a behavioural SPI slave answers each wrt,
// a monitor checks every wrt/vld against queued expectations.
module tb_inert_intf;

  logic        clk;
  logic        rst_n;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] ptch_rt, roll_rt, yaw_rt;
  logic        vld;
  logic        init_done;

  inert_intf #(.PWR_BITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .INT       (INT),
    .done      (done),
    .rd_data   (rd_data),
    .wrt       (wrt),
    .cmd       (cmd),
    .ptch_rt   (ptch_rt),
    .roll_rt   (roll_rt),
    .yaw_rt    (yaw_rt),
    .vld       (vld),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] exp_cmd [$];
  logic [47:0] exp_rate [$];
  logic [7:0]  byte_src [$];

  int wrt_seen  = 0;
  int vld_seen  = 0;
  int done_cnt  = 0;
  bit stale_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SPI slave: done rises ~40 cycles after each wrt; in stale mode the old
  // done level (with garbage data) lingers for a few cycles after wrt first.
  initial begin
    bit is_rd;
    bit aborted;
    done    = 1'b0;
    rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst_n && wrt) begin
        is_rd   = cmd[15];
        aborted = 1'b0;
        if (stale_mode) begin
          rd_data = 16'hEEEE;
          for (int k = 0; k < 5 && !aborted; k++) begin
            @(negedge clk);
            if (!rst_n) aborted = 1'b1;
          end
        end
        done = 1'b0;
        for (int k = 0; k < 40 && !aborted; k++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        if (!aborted) begin
          if (is_rd) begin
            if (byte_src.size() > 0) rd_data = {8'hFF, byte_src.pop_front()};
            else                     rd_data = 16'hDEAD;
          end
          done = 1'b1;
          done_cnt++;
        end
      end
    end
  end

  // Monitor: pops expectations on every wrt and vld, and checks rates hold between vlds.
  initial begin
    logic [47:0] last_rate;
    bit          prev_wrt;
    int          rd_wrts;
    last_rate = '0;
    prev_wrt  = 1'b0;
    rd_wrts   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_rate = '0;
        rd_wrts   = 0;
      end else begin
        if (wrt) begin
          wrt_seen++;
          if (cmd[15]) rd_wrts++;
          chk("wrt_single_cycle", 64'(prev_wrt), 64'd0);
          if (exp_cmd.size() == 0) chk("wrt_expected", 64'd0, 64'd1);
          else                     chk("cmd", 64'(cmd), 64'(exp_cmd.pop_front()));
        end
        if (vld) begin
          vld_seen++;
          chk("wrts_per_vld", 64'(rd_wrts), 64'd6);
          rd_wrts = 0;
          if (exp_rate.size() == 0) chk("vld_expected", 64'd0, 64'd1);
          else                      chk("rates", 64'({ptch_rt, roll_rt, yaw_rt}), 64'(exp_rate.pop_front()));
          last_rate = {ptch_rt, roll_rt, yaw_rt};
        end else begin
          chk("rates_stable", 64'({ptch_rt, roll_rt, yaw_rt}), 64'(last_rate));
        end
      end
      prev_wrt = rst_n && wrt;
    end
  end

  task automatic push_init();
    exp_cmd.push_back(16'h0D02);
    exp_cmd.push_back(16'h1062);
    exp_cmd.push_back(16'h1162);
    exp_cmd.push_back(16'h1460);
  endtask

  task automatic push_read(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                           input logic [47:0] rates);
    exp_cmd.push_back(16'hA200);
    exp_cmd.push_back(16'hA300);
    exp_cmd.push_back(16'hA400);
    exp_cmd.push_back(16'hA500);
    exp_cmd.push_back(16'hA600);
    exp_cmd.push_back(16'hA700);
    byte_src.push_back(b0);
    byte_src.push_back(b1);
    byte_src.push_back(b2);
    byte_src.push_back(b3);
    byte_src.push_back(b4);
    byte_src.push_back(b5);
    exp_rate.push_back(rates);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wrt"}, 64'(wrt), 64'd0);
    chk({tag, "_cmd"}, 64'(cmd), 64'd0);
    chk({tag, "_rates"}, 64'({ptch_rt, roll_rt, yaw_rt}), 64'd0);
    chk({tag, "_vld"}, 64'(vld), 64'd0);
    chk({tag, "_init_done"}, 64'(init_done), 64'd0);
  endtask

  task automatic release_and_time();
    int first;
    first = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int c = 1; c <= 40 && first == 0; c++) begin
      @(posedge clk);
      #1;
      if (wrt) first = c;
    end
    chk("first_wrt_cycle", 64'(first), 64'd15);
    chk("first_wrt_cmd", 64'(cmd), 64'h0D02);
  endtask

  task automatic wait_init(input int done_base);
    int n;
    n = 0;
    while (!init_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("init_done", 64'(init_done), 64'd1);
    chk("dones_before_init_done", 64'(done_cnt - done_base), 64'd4);
  endtask

  task automatic wait_vld(input int target);
    int n;
    n = 0;
    while (vld_seen < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("vld_count", 64'(vld_seen), 64'(target));
  endtask

  task automatic wait_wrts(input int target);
    int n;
    n = 0;
    while (wrt_seen < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wrt_count", 64'(wrt_seen), 64'(target));
  endtask

  task automatic quiet_check(input int vld_target);
    repeat (100) @(negedge clk);
    chk("no_extra_vld", 64'(vld_seen), 64'(vld_target));
    chk("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
    chk("rate_queue_empty", 64'(exp_rate.size()), 64'd0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    INT   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Power-up wait and configuration writes.
    push_init();
    base = done_cnt;
    release_and_time();
    wait_init(base);
    chk("rates_zero_after_init", 64'({ptch_rt, roll_rt, yaw_rt}), 64'd0);

    // Single read burst.
    push_read(8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, {16'h1234, 16'h5678, 16'h9ABC});
    base = wrt_seen;
    INT = 1'b1;
    wait_wrts(base + 1);
    INT = 1'b0;
    wait_vld(1);
    chk("ptch_rt", 64'(ptch_rt), 64'h1234);
    chk("roll_rt", 64'(roll_rt), 64'h5678);
    chk("yaw_rt", 64'(yaw_rt), 64'h9ABC);
    quiet_check(1);

    // Stale done level lingering after each wrt must not count as completion.
    stale_mode = 1'b1;
    push_read(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, {16'h2211, 16'h4433, 16'h6655});
    base = wrt_seen;
    INT = 1'b1;
    wait_wrts(base + 1);
    INT = 1'b0;
    wait_vld(2);
    quiet_check(2);
    stale_mode = 1'b0;

    // INT held high: two back-to-back bursts.
    push_read(8'h01, 8'h80, 8'h02, 8'h7F, 8'hFF, 8'hFF, {16'h8001, 16'h7F02, 16'hFFFF});
    push_read(8'h00, 8'h00, 8'hAA, 8'h55, 8'h0F, 8'hF0, {16'h0000, 16'h55AA, 16'hF00F});
    base = wrt_seen;
    INT = 1'b1;
    wait_wrts(base + 7);
    INT = 1'b0;
    wait_vld(4);
    quiet_check(4);

    // Reset during the third read aborts everything and reruns power-up.
    exp_cmd.push_back(16'hA200);
    exp_cmd.push_back(16'hA300);
    exp_cmd.push_back(16'hA400);
    byte_src.push_back(8'h12);
    byte_src.push_back(8'h34);
    byte_src.push_back(8'h56);
    base = wrt_seen;
    INT = 1'b1;
    wait_wrts(base + 3);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    INT = 1'b0;
    #1;
    check_reset_outputs("midread_reset");
    chk("cmd_queue_at_reset", 64'(exp_cmd.size()), 64'd0);
    byte_src.delete();
    repeat (3) @(negedge clk);
    push_init();
    base = done_cnt;
    release_and_time();
    wait_init(base);
    chk("vld_after_restart", 64'(vld_seen), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inert_intf.md
INERT_INTF -- requirements
Module: inert_intf

Interface
REQ-001 SHALL have parameter PWR_BITS, default 16: width of the power-up wait counter; initialisation starts after 2^PWR_BITS-1 cycles.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port INT  input  1  sensor data-ready, asynchronous level.
REQ-005 SHALL have port done  input  1  SPI master transaction complete; level, high after a transaction until the next wrt is accepted.
REQ-006 SHALL have port rd_data  input  16  SPI master receive word; only [7:0] used.
REQ-007 SHALL have port wrt  output  1  one-cycle request to the SPI master to start a transaction.
REQ-008 SHALL have port cmd  output  16  SPI command word: [15] read flag, [14:8] register address, [7:0] write data or don't-care.
REQ-009 SHALL have port ptch_rt  output  16  signed pitch rate.
REQ-010 SHALL have port roll_rt  output  16  signed roll rate.
REQ-011 SHALL have port yaw_rt  output  16  signed yaw rate.
REQ-012 SHALL have port vld  output  1  one-cycle pulse when all three rate outputs update together.
REQ-013 SHALL have port init_done  output  1  high once the configuration sequence has completed.

Function
REQ-014 SHALL synchronise INT through two flip-flops; only the synchronised level is used.
REQ-015 SHALL detect transaction completion as the rising edge of done (done high, previous-cycle done low); a done level left over from a prior transaction SHALL NOT count as completion.
REQ-016 SHALL implement FSM states PWR_WAIT, INIT_ISSUE, INIT_WAIT, IDLE, RD_ISSUE, RD_WAIT, UPDATE.
REQ-017 In PWR_WAIT, SHALL increment a PWR_BITS-wide counter each cycle and leave for INIT_ISSUE when it reaches all-ones; wrt stays low.
REQ-018 SHALL issue four configuration writes in order: 16'h0D02, 16'h1062, 16'h1162, 16'h1460, using a 2-bit index.
REQ-019 INIT_ISSUE: SHALL drive cmd with the indexed word, pulse wrt for exactly one cycle, go to INIT_WAIT.
REQ-020 INIT_WAIT: on done rising edge SHALL increment the index and return to INIT_ISSUE; after the fourth write SHALL set init_done and go to IDLE.
REQ-021 IDLE: when synchronised INT is high, SHALL go to RD_ISSUE with a 3-bit read index of 0; INT is level-sensitive.
REQ-022 SHALL read six registers in order: 16'hA200 pitch low, 16'hA300 pitch high, 16'hA400 roll low, 16'hA500 roll high, 16'hA600 yaw low, 16'hA700 yaw high.
REQ-023 RD_ISSUE/RD_WAIT: SHALL pulse wrt one cycle per read; on done rising edge SHALL capture rd_data[7:0] into the byte holding register selected by the read index, then increment the index.
REQ-024 After the sixth capture SHALL enter UPDATE. In that cycle it SHALL load ptch_rt={byte1,byte0}, roll_rt={byte3,byte2} and yaw_rt={byte5,byte4} simultaneously, pulse vld for one cycle, and return to IDLE.
REQ-025 Rate outputs SHALL change only in UPDATE; partial reads SHALL never be visible.
REQ-026 cmd SHALL hold its value from the wrt cycle until the next wrt.
REQ-027 If INT is still high on return to IDLE, SHALL start a new read sequence on the next cycle; INT edges during a read sequence SHALL be ignored.
REQ-028 wrt SHALL never be asserted while waiting for done; at most one transaction outstanding.
REQ-029 SHALL have no timeout; a missing done SHALL hold the FSM in its wait state.

Reset
REQ-030 On rst_n low, SHALL asynchronously set state PWR_WAIT, all counters/indices/byte registers 0, wrt 0, cmd 16'h0000, ptch_rt/roll_rt/yaw_rt 16'h0000, vld 0, init_done 0, synchronisers 0.
REQ-031 Reset asserted mid-transaction SHALL abort the sequence; after release the full power-up wait and init sequence SHALL rerun.

Verification
REQ-032 PWR_BITS=4, release reset -> first wrt at cycle 15 after release with cmd=16'h0D02; no wrt before.
REQ-033 SPI model returns done 40 cycles after each wrt -> wrt cmds 0D02,1062,1162,1460 in order, one pulse each; init_done rises after the fourth done.
REQ-034 After init, INT=1, SPI returns bytes 34,12,78,56,BC,9A -> single vld pulse; ptch_rt=16'h1234, roll_rt=16'h5678, yaw_rt=16'h9ABC; outputs remain 0 until that vld.
REQ-035 done held high from the prior transaction when wrt is issued, then dropped and re-raised -> capture occurs only on the re-raise.
REQ-036 INT held high continuously -> back-to-back read sequences, each producing exactly six wrt pulses and one vld.
REQ-037 rst_n pulsed low during the third read -> all outputs 0 immediately, init_done 0, and the sequence restarts with PWR_WAIT.
